// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display-side signal bundle for seg7_scan_driver
//
// Purpose: groups the value input and the multiplexed 7-segment outputs.
// Signals:
//   value     [3:0]  binary value to display (0-15)
//   seg       [6:0]  segments {g,f,e,d,c,b,a}, bit0 = a (pin polarity)
//   dp               decimal point (pin polarity, always inactive)
//   digit_en  [1:0]  [1] = tens digit, [0] = ones digit (pin polarity)
//   frame            1-cycle strobe on the edge where value is sampled
// Modports:
//   master  - the scan driver (consumes value, drives the display pins)
//   slave   - the value source / display side
interface seg7_scan_driver_if;
  logic [3:0] value;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_en;
  logic       frame;

  modport master (
    input  value,
    output seg,
    output dp,
    output digit_en,
    output frame
  );

  modport slave (
    output value,
    input  seg,
    input  dp,
    input  digit_en,
    input  frame
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 2-digit multiplexed 7-segment scan driver with dead-time
//
// Purpose: shows a 4-bit value (0-15) as two decimal digits on a multiplexed
// 7-segment display. Each frame runs BLANK_T -> TENS -> BLANK_O -> ONES; the
// blank phases keep every digit dark between scans to avoid ghosting. The value
// is latched once per frame so a frame never mixes two values.
// Ports:
//   clock     in        system clock
//   reset_n   in        asynchronous active-low reset
//   disp      master    seg7_scan_driver_if (value in; seg/dp/digit_en/frame out)
// Parameters:
//   SCAN_DIV   clocks each digit is lit (>= 2)
//   GHOST_DIV  blank clocks between digits (>= 1)
//   ACTIVE_LOW 1: seg/dp/digit_en inverted at the pins; 0: active-high
// Build option:
//   SEG7_HEX_EN  defined: single-digit hex mode (tens never lit, ONES shows 0-F)
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 25000,
  parameter int GHOST_DIV  = 250,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic                clock,
  input logic                reset_n,
  seg7_scan_driver_if.master disp
);

  localparam int MAX_DIV = (SCAN_DIV > GHOST_DIV) ? SCAN_DIV : GHOST_DIV;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'(GHOST_DIV - 1);

  generate
    if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (GHOST_DIV < 1) begin : g_bad_ghost_div
      $error("seg7_scan_driver: GHOST_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    TENS    = 2'd1,
    BLANK_O = 2'd2,
    ONES    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic             frame_q, frame_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       den_q, den_d;
  logic             sample;

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Phase sequencer: each phase counts 0..N-1 and restarts the counter on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      BLANK_T: if (cnt_q == GHOST_LAST) begin state_d = TENS;    cnt_d = '0; end
      TENS:    if (cnt_q == SCAN_LAST)  begin state_d = BLANK_O; cnt_d = '0; end
      BLANK_O: if (cnt_q == GHOST_LAST) begin state_d = ONES;    cnt_d = '0; end
      ONES:    if (cnt_q == SCAN_LAST)  begin state_d = BLANK_T; cnt_d = '0; end
      default: begin state_d = BLANK_T; cnt_d = '0; end
    endcase
  end

  // Frame-start sampling. Display data is built from shadow_d, not shadow_q,
  // so that with GHOST_DIV=1 the TENS phase entered on the sampling edge
  // already shows the newly sampled value.
  always_comb begin
    sample   = (state_q == BLANK_T) && (cnt_q == '0);
    shadow_d = sample ? disp.value : shadow_q;
    frame_d  = sample;
  end

`ifdef SEG7_HEX_EN
  // Single hex digit on the ones position; tens stays dark.
  always_comb begin
    seg_d = '0;
    den_d = 2'b00;
    if (state_d == ONES) begin
      den_d = 2'b01;
      seg_d = font(shadow_d);
    end
  end
`else
  logic       tens;
  logic [3:0] ones;

  always_comb begin
    tens = (shadow_d >= 4'd10);
    ones = tens ? (shadow_d - 4'd10) : shadow_d;
  end

  // Tens digit is either blank (leading zero) or '1'; ones always shows.
  always_comb begin
    seg_d = '0;
    den_d = 2'b00;
    case (state_d)
      TENS: begin
        if (tens) begin
          den_d = 2'b10;
          seg_d = font(4'd1);
        end
      end
      ONES: begin
        den_d = 2'b01;
        seg_d = font(ones);
      end
      default: begin
        seg_d = '0;
        den_d = 2'b00;
      end
    endcase
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BLANK_T;
      cnt_q    <= '0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      seg_q    <= '0;
      den_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      den_q    <= den_d;
    end
  end

  // Internal logic is active-high; polarity is applied only at the pins.
  assign disp.seg      = ACTIVE_LOW ? ~seg_q : seg_q;
  assign disp.digit_en = ACTIVE_LOW ? ~den_q : den_q;
  assign disp.dp       = ACTIVE_LOW ? 1'b1 : 1'b0;
  assign disp.frame    = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en  = 1'b1;

  seg7_scan_driver_if disp_if ();

  seg7_scan_driver #(
    .SCAN_DIV   (4),
    .GHOST_DIV  (2),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .disp    (disp_if.master)
  );

  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] cap_de    [0:11];
  logic [6:0] cap_seg   [0:11];
  logic       cap_frame [0:11];
  logic       cap_dp_bad;
  int         cap_wait;

  // Waits (bounded) for the next frame strobe, then records one 12-cycle frame
  // sampled on falling edges. k=0 is the strobe cycle.
  task automatic capture(input int change_k, input logic [3:0] change_val);
    cap_wait   = 0;
    cap_dp_bad = 1'b0;
    do begin
      @(negedge clock);
      cap_wait++;
    end while (disp_if.frame !== 1'b1 && cap_wait < 40);
    if (disp_if.frame !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no frame strobe within %0d cycles", cap_wait);
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clock);
      cap_de[k]    = disp_if.digit_en;
      cap_seg[k]   = disp_if.seg;
      cap_frame[k] = disp_if.frame;
      if (disp_if.dp !== 1'b0) cap_dp_bad = 1'b1;
      if (k == change_k) disp_if.value = change_val;
    end
  endtask

  task automatic test_reset;
    logic [1:0] e_de;
    logic [6:0] e_seg;
    disp_if.value = 4'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (disp_if.seg !== 7'h00) begin n_fail++; $display("FAIL rst_seg got %h expected 00", disp_if.seg); end
    n_checks++;
    if (disp_if.digit_en !== 2'b00) begin n_fail++; $display("FAIL rst_den got %b expected 00", disp_if.digit_en); end
    n_checks++;
    if (disp_if.frame !== 1'b0) begin n_fail++; $display("FAIL rst_frame got %b expected 0", disp_if.frame); end
    n_checks++;
    if (disp_if.dp !== 1'b0) begin n_fail++; $display("FAIL rst_dp got %b expected 0", disp_if.dp); end
    reset_n = 1'b1;
    capture(-1, 4'd0);
    n_checks++;
    if (cap_wait !== 1) begin n_fail++; $display("FAIL rst_first_frame got wait %0d expected 1", cap_wait); end
    for (int k = 0; k < 12; k++) begin
      e_de  = (k >= 7 && k <= 10) ? 2'b01 : 2'b00;
      e_seg = (k >= 7 && k <= 10) ? 7'h3F : 7'h00;
      n_checks++;
      if (cap_de[k] !== e_de || cap_seg[k] !== e_seg || cap_frame[k] !== (k == 0)) begin
        n_fail++;
        $display("FAIL t1_k%0d got de=%b seg=%h fr=%b expected de=%b seg=%h fr=%b",
                 k, cap_de[k], cap_seg[k], cap_frame[k], e_de, e_seg, (k == 0));
      end
    end
    n_checks++;
    if (cap_dp_bad !== 1'b0) begin n_fail++; $display("FAIL t1_dp got active expected inactive"); end
  endtask

  task automatic test_value7;
    logic [1:0] e_de;
    logic [6:0] e_seg;
    disp_if.value = 4'd7;
    for (int f = 0; f < 2; f++) begin
      capture(-1, 4'd0);
      n_checks++;
      if (cap_wait !== 1) begin n_fail++; $display("FAIL t2_period f%0d got wait %0d expected 1", f, cap_wait); end
      for (int k = 0; k < 12; k++) begin
        e_de  = (k >= 7 && k <= 10) ? 2'b01 : 2'b00;
        e_seg = (k >= 7 && k <= 10) ? 7'h07 : 7'h00;
        n_checks++;
        if (cap_de[k] !== e_de || cap_seg[k] !== e_seg || cap_frame[k] !== (k == 0)) begin
          n_fail++;
          $display("FAIL t2_f%0d_k%0d got de=%b seg=%h fr=%b expected de=%b seg=%h fr=%b",
                   f, k, cap_de[k], cap_seg[k], cap_frame[k], e_de, e_seg, (k == 0));
        end
      end
    end
  endtask

  // Drives v for the next frame and checks it against the given tens/ones pattern.
  task automatic test_two_digit(input logic [3:0] v, input logic [1:0] t_de,
                                input logic [6:0] t_seg, input logic [6:0] o_seg);
    logic [1:0] e_de;
    logic [6:0] e_seg;
    disp_if.value = v;
    capture(-1, 4'd0);
    for (int k = 0; k < 12; k++) begin
      if (k >= 1 && k <= 4)       begin e_de = t_de;  e_seg = t_seg; end
      else if (k >= 7 && k <= 10) begin e_de = 2'b01; e_seg = o_seg; end
      else                        begin e_de = 2'b00; e_seg = 7'h00; end
      n_checks++;
      if (cap_de[k] !== e_de || cap_seg[k] !== e_seg || cap_frame[k] !== (k == 0)) begin
        n_fail++;
        $display("FAIL val%0d_k%0d got de=%b seg=%h fr=%b expected de=%b seg=%h fr=%b",
                 v, k, cap_de[k], cap_seg[k], cap_frame[k], e_de, e_seg, (k == 0));
      end
    end
  endtask

  task automatic test_no_tear;
    logic [1:0] e_de;
    logic [6:0] e_seg;
    disp_if.value = 4'd3;
    capture(8, 4'd12);
    for (int k = 0; k < 12; k++) begin
      e_de  = (k >= 7 && k <= 10) ? 2'b01 : 2'b00;
      e_seg = (k >= 7 && k <= 10) ? 7'h4F : 7'h00;
      n_checks++;
      if (cap_de[k] !== e_de || cap_seg[k] !== e_seg) begin
        n_fail++;
        $display("FAIL t4_old_k%0d got de=%b seg=%h expected de=%b seg=%h", k, cap_de[k], cap_seg[k], e_de, e_seg);
      end
    end
    capture(-1, 4'd0);
    n_checks++;
    if (cap_wait !== 1) begin n_fail++; $display("FAIL t4_next_frame got wait %0d expected 1", cap_wait); end
    for (int k = 0; k < 12; k++) begin
`ifdef SEG7_HEX_EN
      if (k >= 7 && k <= 10) begin e_de = 2'b01; e_seg = 7'h39; end
      else                   begin e_de = 2'b00; e_seg = 7'h00; end
`else
      if (k >= 1 && k <= 4)       begin e_de = 2'b10; e_seg = 7'h06; end
      else if (k >= 7 && k <= 10) begin e_de = 2'b01; e_seg = 7'h5B; end
      else                        begin e_de = 2'b00; e_seg = 7'h00; end
`endif
      n_checks++;
      if (cap_de[k] !== e_de || cap_seg[k] !== e_seg) begin
        n_fail++;
        $display("FAIL t4_new_k%0d got de=%b seg=%h expected de=%b seg=%h", k, cap_de[k], cap_seg[k], e_de, e_seg);
      end
    end
  endtask

  task automatic test_async_reset;
    int         w;
    logic [1:0] e_de;
    logic [6:0] e_seg;
    disp_if.value = 4'd15;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (disp_if.frame !== 1'b1 && w < 40);
    @(negedge clock);
    @(negedge clock);
    n_checks++;
`ifdef SEG7_HEX_EN
    if (disp_if.digit_en !== 2'b00) begin n_fail++; $display("FAIL t5_pre_den got %b expected 00", disp_if.digit_en); end
`else
    if (disp_if.digit_en !== 2'b10) begin n_fail++; $display("FAIL t5_pre_den got %b expected 10", disp_if.digit_en); end
`endif
    clk_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (disp_if.digit_en !== 2'b00) begin n_fail++; $display("FAIL t5_async_den got %b expected 00", disp_if.digit_en); end
    n_checks++;
    if (disp_if.seg !== 7'h00) begin n_fail++; $display("FAIL t5_async_seg got %h expected 00", disp_if.seg); end
    n_checks++;
    if (disp_if.frame !== 1'b0) begin n_fail++; $display("FAIL t5_async_frame got %b expected 0", disp_if.frame); end
    disp_if.value = 4'd7;
    #1 reset_n = 1'b1;
    #1 clk_en = 1'b1;
    capture(-1, 4'd0);
    n_checks++;
    if (cap_wait !== 1) begin n_fail++; $display("FAIL t5_restart got wait %0d expected 1", cap_wait); end
    for (int k = 0; k < 12; k++) begin
      e_de  = (k >= 7 && k <= 10) ? 2'b01 : 2'b00;
      e_seg = (k >= 7 && k <= 10) ? 7'h07 : 7'h00;
      n_checks++;
      if (cap_de[k] !== e_de || cap_seg[k] !== e_seg || cap_frame[k] !== (k == 0)) begin
        n_fail++;
        $display("FAIL t5_k%0d got de=%b seg=%h fr=%b expected de=%b seg=%h fr=%b",
                 k, cap_de[k], cap_seg[k], cap_frame[k], e_de, e_seg, (k == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    disp_if.value = 4'd0;
    test_reset();
    test_value7();
`ifdef SEG7_HEX_EN
    test_two_digit(4'd15, 2'b00, 7'h00, 7'h71);
    test_two_digit(4'd10, 2'b00, 7'h00, 7'h77);
    test_two_digit(4'd9,  2'b00, 7'h00, 7'h6F);
`else
    test_two_digit(4'd15, 2'b10, 7'h06, 7'h6D);
    test_two_digit(4'd10, 2'b10, 7'h06, 7'h3F);
    test_two_digit(4'd9,  2'b00, 7'h00, 7'h6F);
`endif
    test_no_tear();
    test_async_reset();
`ifdef SEG7_HEX_EN
    test_two_digit(4'hB, 2'b00, 7'h00, 7'h7C);
`else
    test_two_digit(4'hB, 2'b10, 7'h06, 7'h06);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
